sbus_tx: RTL and testbench

- SBUS frame encoder and serial transmitter; the transmit-side counterpart of the SBUS receive and decode path.
- Packs 16 × 11-bit channels plus a flags byte into the standard 25-byte SBUS frame and serialises it as 100 kbaud 8E2.
- Serves three uses: loopback verification of the receiver, HIL stimulus, and forwarding stick data to a downstream flight controller.
- Runs on the 50 MHz system clock (clk_w domain); supports single-shot or free-running frame generation.

---
 rtl/sbus_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_sbus_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbus_tx.sv
// sbus_tx -- SBUS frame encoder and serial transmitter.
//
// Holds a 16 x 11-bit channel register file, packs it together with a flags
// nibble into the 25-byte SBUS frame and shifts it out as 8E2 serial data.
// Frames are launched one at a time on 'start', or back-to-back with a fixed
// idle gap while 'auto_en' is high.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset (aborts any frame in flight)
//   ch_wr    channel register write strobe
//   ch_addr  channel index 0..15
//   ch_data  11-bit channel value
//   flags    {failsafe, frame_lost, ch18, ch17}, captured at frame launch
//   start    single-cycle request for one frame
//   auto_en  continuous frame generation enable
//   tx       serial line output (polarity set by INVERT)
//   busy     high from LOAD through the last stop bit of the frame
//   done     one-cycle pulse after the last stop bit

module sbus_tx #(
    parameter int unsigned CLKS_PER_BIT   = 500,
    parameter int unsigned FRAME_GAP_CLKS = 300000,
    parameter bit          INVERT         = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch_wr,
    input  logic [3:0]  ch_addr,
    input  logic [10:0] ch_data,
    input  logic [3:0]  flags,
    input  logic        start,
    input  logic        auto_en,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned BitCntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned GapCntW = (FRAME_GAP_CLKS > 1) ? $clog2(FRAME_GAP_CLKS) : 1;

    localparam logic [BitCntW-1:0] BitLast  = BitCntW'(CLKS_PER_BIT - 1);
    localparam logic [GapCntW-1:0] GapLast  = GapCntW'(FRAME_GAP_CLKS - 1);
    localparam logic [4:0]         LastByte = 5'd24;

    // Line levels after polarity inversion; the stop bits equal the idle level.
    localparam logic LineIdle  = 1'b1 ^ INVERT;
    localparam logic LineStart = 1'b0 ^ INVERT;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2,
        StGap
    } state_e;

    state_e              state_q;
    logic [10:0]         ch_reg_q [16];
    logic [175:0]        snap_q;       // packed channel snapshot for the frame on the line
    logic [3:0]          flags_q;
    logic [4:0]          byte_idx_q;
    logic [2:0]          bit_idx_q;
    logic [BitCntW-1:0]  clk_cnt_q;
    logic [GapCntW-1:0]  gap_cnt_q;
    logic [7:0]          shift_q;
    logic                parity_q;

    logic [175:0]        ch_packed;
    logic [7:0]          cur_byte;
    logic                bit_end;
    logic                in_bit_state;

    // Channel i bit j lands on packed bit 11*i + j.
    always_comb begin
        ch_packed = '0;
        for (int i = 0; i < 16; i++) begin
            ch_packed[11*i +: 11] = ch_reg_q[i];
        end
    end

    // Frame byte selected by the current byte index.
    always_comb begin
        cur_byte = 8'h00;
        if (byte_idx_q == 5'd0) begin
            cur_byte = 8'h0F;
        end else if (byte_idx_q <= 5'd22) begin
            cur_byte = snap_q[{byte_idx_q - 5'd1, 3'b000} +: 8];
        end else if (byte_idx_q == 5'd23) begin
            cur_byte = {4'b0000, flags_q};
        end
    end

    assign bit_end      = (clk_cnt_q == BitLast);
    assign in_bit_state = (state_q == StStart) || (state_q == StData) ||
                          (state_q == StParity) || (state_q == StStop1) ||
                          (state_q == StStop2);

    // tx is registered: every transition into a bit state also loads the
    // level of that bit, so the line changes exactly on the bit boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            for (int i = 0; i < 16; i++) begin
                ch_reg_q[i] <= '0;
            end
            snap_q     <= '0;
            flags_q    <= '0;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            clk_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx         <= LineIdle;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            if (ch_wr) begin
                ch_reg_q[ch_addr] <= ch_data;
            end

            if (in_bit_state) begin
                clk_cnt_q <= bit_end ? '0 : clk_cnt_q + 1'b1;
            end

            unique case (state_q)
                // The inter-frame gap is only enforced in StGap, so auto_en
                // seen in IDLE launches at once.
                StIdle: begin
                    if (start || auto_en) begin
                        busy    <= 1'b1;
                        state_q <= StLoad;
                    end
                end

                StLoad: begin
                    snap_q     <= ch_packed;
                    flags_q    <= flags;
                    byte_idx_q <= '0;
                    clk_cnt_q  <= '0;
                    tx         <= LineStart;
                    state_q    <= StStart;
                end

                StStart: begin
                    if (bit_end) begin
                        shift_q   <= cur_byte;
                        parity_q  <= ^cur_byte;
                        bit_idx_q <= '0;
                        tx        <= cur_byte[0] ^ INVERT;
                        state_q   <= StData;
                    end
                end

                // shift_q[0] is the bit on the line; shift_q[1] is next.
                StData: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            tx      <= parity_q ^ INVERT;
                            state_q <= StParity;
                        end else begin
                            tx        <= shift_q[1] ^ INVERT;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end

                StParity: begin
                    if (bit_end) begin
                        tx      <= LineIdle;
                        state_q <= StStop1;
                    end
                end

                StStop1: begin
                    if (bit_end) begin
                        state_q <= StStop2;
                    end
                end

                StStop2: begin
                    if (bit_end) begin
                        if (byte_idx_q != LastByte) begin
                            byte_idx_q <= byte_idx_q + 5'd1;
                            tx         <= LineStart;
                            state_q    <= StStart;
                        end else begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            gap_cnt_q <= '0;
                            state_q   <= auto_en ? StGap : StIdle;
                        end
                    end
                end

                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        if (auto_en) begin
                            busy    <= 1'b1;
                            state_q <= StLoad;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbus_tx.sv
// Self-checking bench for sbus_tx. Two instances share all inputs, one with
// plain polarity and one inverted. Each frame is sampled mid-bit off the line
// and compared, byte by byte, with a frame assembled from a channel model.

module tb_sbus_tx;

    localparam int unsigned CPB = 4;
    localparam int unsigned GAP = 10;
    localparam int FRAME_CLKS = 300 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        ch_wr;
    logic [3:0]  ch_addr;
    logic [10:0] ch_data;
    logic [3:0]  flags;
    logic        start;
    logic        auto_en;
    logic        tx, busy, done;
    logic        tx_inv, busy_inv, done_inv;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [10:0] ch_m [16];       // model of the channel register file
    logic [11:0] exp_w [25];      // expected line words, bit 0 first on the line
    logic [11:0] cap [25];
    logic [11:0] cap_inv [25];

    sbus_tx #(
        .CLKS_PER_BIT   (CPB),
        .FRAME_GAP_CLKS (GAP),
        .INVERT         (1'b0)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .ch_wr   (ch_wr),
        .ch_addr (ch_addr),
        .ch_data (ch_data),
        .flags   (flags),
        .start   (start),
        .auto_en (auto_en),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    sbus_tx #(
        .CLKS_PER_BIT   (CPB),
        .FRAME_GAP_CLKS (GAP),
        .INVERT         (1'b1)
    ) u_dut_inv (
        .clk     (clk),
        .rst     (rst),
        .ch_wr   (ch_wr),
        .ch_addr (ch_addr),
        .ch_data (ch_data),
        .flags   (flags),
        .start   (start),
        .auto_en (auto_en),
        .tx      (tx_inv),
        .busy    (busy_inv),
        .done    (done_inv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns on the falling edge that follows rising edge number e.
    task automatic at_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic write_ch(input logic [3:0] a, input logic [10:0] d);
        ch_wr   = 1'b1;
        ch_addr = a;
        ch_data = d;
        @(negedge clk);
        ch_wr   = 1'b0;
        ch_m[a] = d;
    endtask

    task automatic random_channels();
        for (int a = 0; a < 16; a++) begin
            write_ch(4'(a), 11'($urandom_range(0, 2047)));
        end
    endtask

    // Frame from the model: header, 176 packed channel bits, flags, end byte.
    task automatic build_expected();
        logic [7:0] b;
        int p;
        for (int k = 0; k < 25; k++) begin
            b = 8'h00;
            if (k == 0) begin
                b = 8'h0F;
            end else if (k <= 22) begin
                for (int j = 0; j < 8; j++) begin
                    p = 8 * (k - 1) + j;
                    b[j] = ch_m[p / 11][p % 11];
                end
            end else if (k == 23) begin
                b = {4'b0000, flags};
            end
            exp_w[k] = {2'b11, ^b, b, 1'b0};
        end
    endtask

    // Called on a falling edge; n is the edge on which start is sampled.
    task automatic launch(output int n);
        start = 1'b1;
        n = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // n is the edge on which LOAD is entered. Optional side actions during the
    // frame: a channel write, a stray start pulse, and dropping auto_en.
    task automatic capture_frame(input int n, input bit mid_wr, input logic [3:0] wa,
                                 input logic [10:0] wd, input bit drop_auto);
        for (int k = 0; k < 300; k++) begin
            at_edge(n + 1 + k * CPB + CPB / 2);
            cap[k / 12][k % 12]     = tx;
            cap_inv[k / 12][k % 12] = tx_inv;
            if (mid_wr && k == 50) begin
                ch_wr   = 1'b1;
                ch_addr = wa;
                ch_data = wd;
                ch_m[wa] = wd;
            end
            if (k == 51) ch_wr = 1'b0;
            if (k == 100) start = 1'b1;
            if (k == 101) start = 1'b0;
            if (k == 150) begin
                check_eq("busy_mid", {31'b0, busy}, 32'd1);
                check_eq("busy_mid_inv", {31'b0, busy_inv}, 32'd1);
                if (drop_auto) auto_en = 1'b0;
            end
        end
        for (int b = 0; b < 25; b++) begin
            check_eq($sformatf("byte%0d", b), {20'b0, cap[b]}, {20'b0, exp_w[b]});
            check_eq($sformatf("byte%0d_inv", b), {20'b0, ~cap_inv[b]}, {20'b0, exp_w[b]});
        end
        at_edge(n + FRAME_CLKS);
        check_eq("done_early", {31'b0, done}, 32'd0);
        check_eq("busy_last", {31'b0, busy}, 32'd1);
        at_edge(n + 1 + FRAME_CLKS);
        check_eq("done_pulse", {31'b0, done}, 32'd1);
        check_eq("done_pulse_inv", {31'b0, done_inv}, 32'd1);
        check_eq("busy_end", {31'b0, busy}, 32'd0);
        check_eq("tx_end", {31'b0, tx}, 32'd1);
    endtask

    task automatic single_frame(input bit mid_wr, input logic [3:0] wa, input logic [10:0] wd);
        int n;
        build_expected();
        launch(n);
        capture_frame(n, mid_wr, wa, wd, 1'b0);
    endtask

    initial begin
        int n, d, d2;
        rst = 1'b1;
        ch_wr = 1'b0;
        ch_addr = '0;
        ch_data = '0;
        flags = '0;
        start = 1'b0;
        auto_en = 1'b0;
        for (int a = 0; a < 16; a++) ch_m[a] = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", {31'b0, tx}, 32'd1);
        check_eq("rst_tx_inv", {31'b0, tx_inv}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // All-zero frame.
        single_frame(1'b0, 4'd0, 11'd0);

        // Channel 0 full scale.
        write_ch(4'd0, 11'h7FF);
        single_frame(1'b0, 4'd0, 11'd0);

        // Channel 1 MSB plus frame_lost/failsafe.
        write_ch(4'd0, 11'h000);
        write_ch(4'd1, 11'h400);
        flags = 4'b1100;
        single_frame(1'b0, 4'd0, 11'd0);

        // Write during a frame only shows up in the next one.
        write_ch(4'd1, 11'h000);
        flags = 4'b0000;
        single_frame(1'b1, 4'd0, 11'h123);
        single_frame(1'b0, 4'd0, 11'd0);

        // Randomised frames with random mid-frame writes.
        for (int r = 0; r < 3; r++) begin
            random_channels();
            flags = 4'($urandom_range(0, 15));
            single_frame(1'b1, 4'($urandom_range(0, 15)), 11'($urandom_range(0, 2047)));
        end

        // Free-running mode: start and auto_en together, two frames, then stop.
        random_channels();
        flags = 4'($urandom_range(0, 15));
        build_expected();
        start = 1'b1;
        auto_en = 1'b1;
        n = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        capture_frame(n, 1'b1, 4'($urandom_range(0, 15)), 11'($urandom_range(0, 2047)), 1'b0);
        d = n + 1 + FRAME_CLKS;
        at_edge(d + GAP / 2);
        start = 1'b1;
        check_eq("gap_busy", {31'b0, busy}, 32'd0);
        check_eq("gap_tx", {31'b0, tx}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        build_expected();
        capture_frame(d + GAP, 1'b0, 4'd0, 11'd0, 1'b1);
        d2 = d + GAP + 1 + FRAME_CLKS;
        at_edge(d2 + GAP + 5);
        check_eq("no_relaunch_busy", {31'b0, busy}, 32'd0);
        check_eq("no_relaunch_tx", {31'b0, tx}, 32'd1);

        // Reset in the middle of byte 5.
        random_channels();
        build_expected();
        launch(n);
        at_edge(n + 1 + (5 * 12 + 4) * CPB + 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_tx", {31'b0, tx}, 32'd1);
        check_eq("abort_tx_inv", {31'b0, tx_inv}, 32'd0);
        check_eq("abort_busy", {31'b0, busy}, 32'd0);
        check_eq("abort_busy_inv", {31'b0, busy_inv}, 32'd0);
        check_eq("abort_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        for (int a = 0; a < 16; a++) ch_m[a] = '0;
        flags = 4'($urandom_range(0, 15));
        single_frame(1'b0, 4'd0, 11'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
